// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory and buffers {pc, inst}
// pairs in a small registered FIFO toward decode, with redirect and misalignment trap.
module pc_fetch_unit #(
    parameter int                    PC_WIDTH    = 32,
    parameter int                    INST_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [PC_WIDTH-1:0]   imem_pc_o,
    input  logic [INST_WIDTH-1:0] imem_inst_i,
    input  logic                  redirect_valid_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [PC_WIDTH-1:0]   out_pc_o,
    output logic [INST_WIDTH-1:0] out_inst_o,
    output logic                  fault_o,
    output logic [PC_WIDTH-1:0]   fault_pc_o
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    state_t                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [PC_WIDTH-1:0]     fault_pc_q, fault_pc_d;
    logic [CW-1:0]           count_q, count_d;
    logic [PC_WIDTH-1:0]     q_pc_q   [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]     q_pc_d   [QUEUE_DEPTH];
    logic [INST_WIDTH-1:0]   q_inst_q [QUEUE_DEPTH];
    logic [INST_WIDTH-1:0]   q_inst_d [QUEUE_DEPTH];

    logic          pop;
    logic          push;
    logic          can_push;
    logic [CW-1:0] pop_ext;
    logic [CW-1:0] wr_idx;

    assign out_valid_o = (count_q != '0);
    assign out_pc_o    = out_valid_o ? q_pc_q[0]   : '0;
    assign out_inst_o  = out_valid_o ? q_inst_q[0] : '0;
    assign imem_pc_o   = pc_q;
    assign fault_o     = (state_q == ST_FAULT);
    assign fault_pc_o  = fault_pc_q;

    always_comb begin
        pop        = out_valid_o & out_ready_i;
        pop_ext    = {{(CW-1){1'b0}}, pop};
        can_push   = (state_q == ST_RUN) && ((count_q < DEPTH_C) || pop);
        wr_idx     = count_q - pop_ext;
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q - pop_ext;
        push       = 1'b0;

        if (redirect_valid_i) begin
            // Flush wins over fetch; a head popped this cycle is still consumed.
            count_d = '0;
            pc_d    = redirect_pc_i;
            if (redirect_pc_i[1:0] != 2'b00) begin
                state_d    = ST_FAULT;
                fault_pc_d = redirect_pc_i;
            end else begin
                state_d = ST_RUN;
            end
        end else if (can_push) begin
            push    = 1'b1;
            pc_d    = pc_q + PC_WIDTH'(4);
            count_d = count_q - pop_ext + CW'(1);
        end

        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            q_pc_d[i]   = q_pc_q[i];
            q_inst_d[i] = q_inst_q[i];
            if (pop && (i < QUEUE_DEPTH - 1)) begin
                q_pc_d[i]   = q_pc_q[i+1];
                q_inst_d[i] = q_inst_q[i+1];
            end
            // Tail slot is computed after the pop shift so push+pop on a full queue works.
            if (push && (wr_idx == CW'(i))) begin
                q_pc_d[i]   = pc_q;
                q_inst_d[i] = imem_inst_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            fault_pc_q <= '0;
            count_q    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc_q[i]   <= '0;
                q_inst_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc_q[i]   <= q_pc_d[i];
                q_inst_q[i] <= q_inst_d[i];
            end
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Fetch stage that sits directly upstream of the instruction memory. It holds the program counter, drives the memory's PC input, and captures the instruction the memory returns in the same cycle. Each {pc, inst} pair goes into a 2-entry queue that feeds decode over a valid/ready handshake. The block also handles branch/jump redirects (with queue flush) and traps misaligned redirect targets, because the instruction memory returns high-Z for any PC[1:0] != 0.

Parameters:
PC_WIDTH, 32, width of program counter and all PC ports
INST_WIDTH, 32, width of instruction word
RESET_PC, 32'h0000_0000, PC value loaded on reset
QUEUE_DEPTH, 2, fetch queue entries (fixed at 2; other values unsupported)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
imem_pc  out  PC_WIDTH  PC to instruction memory, driven directly from the PC register
imem_inst  in  INST_WIDTH  instruction from instruction memory, combinational same-cycle return
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  PC_WIDTH  redirect target
out_valid  out  1  queue head valid toward decode
out_ready  in  1  decode accepts head this cycle
out_pc  out  PC_WIDTH  PC of head entry (0 when empty)
out_inst  out  INST_WIDTH  instruction of head entry (0 when empty)
fault  out  1  misaligned-target trap active
fault_pc  out  PC_WIDTH  offending target captured at trap

Behaviour:
- Reset (async, immediate): pc=RESET_PC, queue count=0, state=RUN, out_valid=0, out_pc=0, out_inst=0, fault=0, fault_pc=0. Reset asserted mid-operation discards all queued entries.
- States are RUN and FAULT. FAULT -> RUN only on an aligned redirect. RUN -> FAULT on a misaligned redirect.
- pop = out_valid & out_ready.
- can_push = state==RUN & (count<2 | pop).
- Priority each cycle: rst > redirect > normal fetch.
- Normal fetch (RUN, no redirect, can_push):
  - push {pc, imem_inst} at tail.
  - pc <= pc+4.
  - Push and pop in the same cycle are legal, including when the queue is full; count is unchanged in that case.
- Stall (queue full, no pop): pc holds, imem_pc is stable, no push.
- Latency: an instruction fetched at cycle N appears on out_* at cycle N+1. Sustained throughput is 1 instruction/cycle with out_ready held high.
- Redirect (redirect_valid=1):
  - Queue is flushed to count=0 next cycle. A head popped in the same cycle counts as consumed.
  - No push that cycle.
  - pc <= redirect_pc.
  - If redirect_pc[1:0]!=0: state <= FAULT, fault <= 1, fault_pc <= redirect_pc.
  - Otherwise: state <= RUN, fault <= 0.
- FAULT: no pushes, pc holds the misaligned value, out_valid=0 once flushed, fault and fault_pc hold until the next aligned redirect.
- A redirect while in FAULT with another misaligned target updates fault_pc and stays in FAULT.
- Arithmetic: pc+4 wraps modulo 2^PC_WIDTH with no flag. PC bits above the memory's word range are passed through unchecked.
- Queue ordering: strict FIFO. The head is registered; out_* change only on clock edges or reset.
- out_valid=1 must stay asserted with out_pc/out_inst stable until pop.

Test Plan:
- Reset then out_ready=1 → imem_pc=0 during reset; after release out_pc sequence 0,4,8,12 on consecutive cycles with out_inst equal to memory words 0..3.
- out_ready=0 for 4 cycles from reset → queue holds pc 0,4; imem_pc frozen at 8. Raise ready → out_pc 0,4,8,... with no gap or duplicate.
- Queue full, then redirect_valid=1 with redirect_pc=0x100 and out_ready=1 → next cycle out_valid=0, imem_pc=0x100; following cycle out_pc=0x100; entries 0,4 never reappear.
- Redirect to 0x102 → fault=1, fault_pc=0x102, out_valid=0, imem_pc stays 0x102 for 5 cycles. Then redirect to 0x200 → fault=0, out_pc=0x200 two cycles later.
- Redirect to 0xFFFF_FFFC → out_pc sequence 0xFFFF_FFFC then 0x0000_0000.
- Assert rst asynchronously mid-stream with 2 entries queued → out_valid=0, fault=0, imem_pc=RESET_PC immediately, before the next clock edge.
